// File: rtl/jt49_pkg.sv
// Shared constants for the JT49 envelope control path: register map and
// shape-register bit positions.
package jt49_pkg;

  localparam logic [1:0] JT49_EG_FINE   = 2'd0;
  localparam logic [1:0] JT49_EG_COARSE = 2'd1;
  localparam logic [1:0] JT49_EG_SHAPE  = 2'd2;

  localparam int CONT = 3;
  localparam int ATT  = 2;
  localparam int ALT  = 1;
  localparam int HOLD = 0;

endpackage

// File: rtl/jt49_cen_div.sv
// Clock-enable prescaler: emits a one-cycle tick on every DIV-th cen pulse.
// Shared by the envelope, tone and noise timers.
module jt49_cen_div #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = cen && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (cen) cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jt49_eg_timer.sv
// Envelope control: owns the period/shape registers and produces the step
// square wave, null-period flag and restart pulse consumed by the shaper.
module jt49_eg_timer
  import jt49_pkg::*;
#(
  parameter int DIV = 8,
  parameter int PW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          wr,
  input  logic [1:0]    addr,
  input  logic [7:0]    din,
  output logic          step,
  output logic          null_period,
  output logic          restart,
  output logic [3:0]    ctrl,
  output logic [PW-1:0] period,
  output logic [7:0]    dout
);

  logic          tick;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] p_eff;
  logic [PW:0]   cnt_inc;
  logic [3:0]    ctrl_q, ctrl_d;
  logic          step_q, step_d;
  logic          null_q;
  logic          restart_q;

  jt49_cen_div #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .tick  (tick)
  );

  always_comb begin
    period_d = period_q;
    ctrl_d   = ctrl_q;
    if (wr) begin
      case (addr)
        JT49_EG_FINE:   period_d[7:0]    = din;
        JT49_EG_COARSE: period_d[PW-1:8] = din[PW-9:0];
        JT49_EG_SHAPE:  ctrl_d = {din[CONT], din[ATT], din[ALT], din[HOLD]};
        default: ;
      endcase
    end
  end

  // One extra compare bit keeps cnt+1 from wrapping at the top period.
  assign p_eff   = (period_q == '0) ? PW'(1) : period_q;
  assign cnt_inc = {1'b0, cnt_q} + (PW+1)'(1);

  always_comb begin
    cnt_d  = cnt_q;
    step_d = step_q;
    if (tick) begin
      if (cnt_inc >= {1'b0, p_eff}) begin
        cnt_d  = '0;
        step_d = ~step_q;
      end else begin
        cnt_d = cnt_inc[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q  <= '0;
      ctrl_q    <= 4'h0;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      null_q    <= 1'b1;
      restart_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      null_q    <= (period_q == '0);
      restart_q <= wr && (addr == JT49_EG_SHAPE);
    end
  end

  always_comb begin
    dout = 8'h00;
    case (addr)
      JT49_EG_FINE:   dout = period_q[7:0];
      JT49_EG_COARSE: dout = period_q[PW-1:8];
      JT49_EG_SHAPE:  dout = {4'h0, ctrl_q};
      default:        dout = 8'h00;
    endcase
  end

  assign step        = step_q;
  assign null_period = null_q;
  assign restart     = restart_q;
  assign ctrl        = ctrl_q;
  assign period      = period_q;

endmodule

// File: tb/tb_jt49_eg_timer.sv
// Self-checking bench for jt49_eg_timer: two instances (DIV=2 and DIV=8)
// share one stimulus bus; register writes are scoreboarded, timing is measured.
module tb_jt49_eg_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [7:0]  din = 8'h00;

  logic        step2, null2, restart2;
  logic [3:0]  ctrl2;
  logic [15:0] period2;
  logic [7:0]  dout2;
  logic        step8, null8, restart8;
  logic [3:0]  ctrl8;
  logic [15:0] period8;
  logic [7:0]  dout8;

  always #5 clk = ~clk;

  jt49_eg_timer #(.DIV(2), .PW(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr(wr), .addr(addr), .din(din),
    .step(step2), .null_period(null2), .restart(restart2), .ctrl(ctrl2),
    .period(period2), .dout(dout2)
  );

  jt49_eg_timer #(.DIV(8), .PW(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr(wr), .addr(addr), .din(din),
    .step(step8), .null_period(null8), .restart(restart8), .ctrl(ctrl8),
    .period(period8), .dout(dout8)
  );

  typedef struct packed {
    logic [1:0]  addr;
    logic [7:0]  din;
    logic [15:0] period;
    logic [3:0]  ctrl;
    logic        restart;
    logic [7:0]  dout;
  } vec_t;

  vec_t tbl [9];
  vec_t sb [$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic bit stp(input bit sel);
    return sel ? step8 : step2;
  endfunction

  // Clocks until the next step edge (rising only if requested), -1 on timeout.
  task automatic wait_edge(input bit sel, input bit rising_only, input int bound, output int n);
    bit prev, cur;
    prev = stp(sel);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      cur = stp(sel);
      if (cur != prev && (!rising_only || cur)) begin
        n = i;
        return;
      end
      prev = cur;
    end
  endtask

  task automatic measure(input bit sel, input int nper, input int exp_gap, input string name);
    int n;
    wait_edge(sel, 1'b1, 2*exp_gap + 8, n);
    chk({name, "_sync"}, 32'(n >= 0), 32'd1);
    for (int k = 0; k < nper; k++) begin
      wait_edge(sel, 1'b1, 2*exp_gap + 8, n);
      chk(name, 32'(n), 32'(exp_gap));
    end
  endtask

  task automatic count_toggles(input bit sel, input int clks, output int tog);
    bit prev;
    prev = stp(sel);
    tog = 0;
    repeat (clks) begin
      @(negedge clk);
      if (stp(sel) != prev) tog++;
      prev = stp(sel);
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; din = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_step2"},   32'(step2),    32'd0);
    chk({name, "_step8"},   32'(step8),    32'd0);
    chk({name, "_null"},    32'(null8),    32'd1);
    chk({name, "_restart"}, 32'(restart8), 32'd0);
    chk({name, "_ctrl"},    32'(ctrl8),    32'd0);
    chk({name, "_period"},  32'(period8),  32'd0);
    chk({name, "_period2"}, 32'(period2),  32'd0);
    chk({name, "_dout"},    32'(dout8),    32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t e;
    int   n, tog;
    bit   prev, cur;
    int   gap;

    //          addr  din    period    ctrl  rst   dout
    tbl[0] = '{2'd0, 8'h04, 16'h0004, 4'h0, 1'b0, 8'h04};
    tbl[1] = '{2'd1, 8'h12, 16'h1204, 4'h0, 1'b0, 8'h12};
    tbl[2] = '{2'd2, 8'hFD, 16'h1204, 4'hD, 1'b1, 8'h0D};
    tbl[3] = '{2'd3, 8'h55, 16'h1204, 4'hD, 1'b0, 8'h00};
    tbl[4] = '{2'd2, 8'h30, 16'h1204, 4'h0, 1'b1, 8'h00};
    tbl[5] = '{2'd0, 8'h00, 16'h1200, 4'h0, 1'b0, 8'h00};
    tbl[6] = '{2'd1, 8'h00, 16'h0000, 4'h0, 1'b0, 8'h00};
    tbl[7] = '{2'd2, 8'h0A, 16'h0000, 4'hA, 1'b1, 8'h0A};
    tbl[8] = '{2'd0, 8'h04, 16'h0004, 4'hA, 1'b0, 8'h04};

    // Reset, then period 0 behaves as period 1.
    cen = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    measure(1'b0, 3, 4, "gap_p0_div2");
    measure(1'b1, 2, 16, "gap_p0_div8");
    chk("null_p0", 32'(null2), 32'd1);
    wr_reg(2'd0, 8'h03);
    chk("null_1clk", 32'(null8), 32'd1);
    @(negedge clk);
    chk("null_2clk", 32'(null8), 32'd0);
    chk("null_2clk_d2", 32'(null2), 32'd0);

    // Register writes with cen held low.
    cen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr = 1'b1; addr = tbl[i].addr; din = tbl[i].din;
      sb.push_back(tbl[i]);
      @(negedge clk);
      wr = 1'b0;
      e = sb.pop_front();
      chk($sformatf("v%0d_period", i),  32'(period8),  32'(e.period));
      chk($sformatf("v%0d_period2", i), 32'(period2),  32'(e.period));
      chk($sformatf("v%0d_ctrl", i),    32'(ctrl8),    32'(e.ctrl));
      chk($sformatf("v%0d_restart", i), 32'(restart8), 32'(e.restart));
      chk($sformatf("v%0d_dout", i),    32'(dout8),    32'(e.dout));
      @(negedge clk);
      chk($sformatf("v%0d_restart_end", i), 32'(restart8), 32'd0);
      chk($sformatf("v%0d_null", i), 32'(null8), 32'(e.period == 16'h0000));
    end

    // Back-to-back shape writes.
    wr = 1'b1; addr = 2'd2; din = 8'h03;
    @(negedge clk);
    chk("b2b_restart1", 32'(restart8), 32'd1);
    chk("b2b_ctrl1", 32'(ctrl8), 32'h3);
    din = 8'h0C;
    @(negedge clk);
    wr = 1'b0;
    chk("b2b_restart2", 32'(restart8), 32'd1);
    chk("b2b_ctrl2", 32'(ctrl8), 32'hC);
    @(negedge clk);
    chk("b2b_restart_end", 32'(restart8), 32'd0);

    // Period 4: 2*4*DIV clocks between rising edges.
    cen = 1'b1;
    measure(1'b1, 10, 64, "gap_p4_div8");
    measure(1'b0, 2, 16, "gap_p4_div2");

    // Shape write mid-period must not disturb step phase; addr 3 gives no restart.
    wait_edge(1'b1, 1'b1, 200, n);
    chk("c_sync", 32'(n >= 0), 32'd1);
    prev = 1'b1;
    gap = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      cur = step8;
      if (i == 21) begin
        chk("c_restart", 32'(restart8), 32'd1);
        chk("c_ctrl", 32'(ctrl8), 32'hD);
        chk("c_ctrl2", 32'(ctrl2), 32'hD);
      end
      if (i == 22) chk("c_restart_end", 32'(restart8), 32'd0);
      if (i == 31 || i == 32) chk("c_addr3_norestart", 32'(restart8), 32'd0);
      if (cur && !prev) begin
        gap = i;
        break;
      end
      prev = cur;
      wr = 1'b0;
      if (i == 20) begin wr = 1'b1; addr = 2'd2; din = 8'hFD; end
      if (i == 30) begin wr = 1'b1; addr = 2'd3; din = 8'hFF; end
    end
    wr = 1'b0;
    chk("c_shape_phase", 32'(gap), 32'd64);

    // Period 0x0100, count to ~0x80, then shrink to 0x10: expire on next tick.
    wr_reg(2'd0, 8'h00);
    wr_reg(2'd1, 8'h01);
    wait_edge(1'b0, 1'b0, 600, n);
    chk("d_sync", 32'(n >= 0), 32'd1);
    count_toggles(1'b0, 250, tog);
    chk("d_no_early", 32'(tog), 32'd0);
    wr_reg(2'd0, 8'h10);
    wr_reg(2'd1, 8'h00);
    wait_edge(1'b0, 1'b0, 4, n);
    chk("d_next_tick", 32'(n == 1 || n == 2), 32'd1);
    wait_edge(1'b0, 1'b0, 40, n);
    chk("d_gap16", 32'(n), 32'd32);
    wait_edge(1'b0, 1'b0, 40, n);
    chk("d_gap16b", 32'(n), 32'd32);

    // Period 0xFFFF holds step; dropping to 0x00FF below cnt expires without wrap.
    wr_reg(2'd0, 8'hFF);
    wr_reg(2'd1, 8'hFF);
    count_toggles(1'b0, 1000, tog);
    chk("e_ffff_hold", 32'(tog), 32'd0);
    chk("e_period", 32'(period2), 32'hFFFF);
    wr_reg(2'd1, 8'h00);
    wait_edge(1'b0, 1'b0, 4, n);
    chk("e_no_wrap", 32'(n == 1 || n == 2), 32'd1);
    wait_edge(1'b0, 1'b0, 600, n);
    chk("e_gap_ff", 32'(n), 32'd510);

    // Reset asserted while restart is high.
    wr = 1'b1; addr = 2'd2; din = 8'h05;
    @(negedge clk);
    wr = 1'b0;
    chk("f_pulse", 32'(restart8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("f_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("f_no_restart", 32'(restart8), 32'd0);
      chk("f_no_restart2", 32'(restart2), 32'd0);
    end
    chk("f_null", 32'(null8), 32'd1);
    measure(1'b0, 2, 4, "f_gap_p0");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
